// File: rtl/vblank_scheduler.sv
// Round-robin arbiter that hands out the vertical-blanking window to
// game-logic requesters, one exclusive grant at a time, once per frame.
module vblank_scheduler #(
    parameter int N_REQ      = 4,
    parameter int MAX_CYCLES = 4096,
    parameter int CLOSE_LINE = 627
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vblnk,
    input  logic [10:0]      vcount,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] gnt,
    output logic             frame_start,
    output logic             timeout,
    output logic             overrun,
    output logic [15:0]      frame_cnt,
    output logic             idle
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        GRANT
    } state_t;

    state_t           state, state_n;
    logic [N_REQ-1:0] gnt_n;
    logic [PW-1:0]    ptr, ptr_n;
    logic [PW-1:0]    owner, owner_n;
    logic [N_REQ-1:0] served, served_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             vblnk_d;
    logic             fs_n;
    logic             to_n;
    logic             ov_n;
    logic [15:0]      fc_n;

    logic             open_win;
    logic             close_win;
    logic [N_REQ-1:0] pending;
    logic             hit;
    logic [PW-1:0]    hit_idx;

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base,
                                               input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_REQ) s = s - N_REQ;
        return PW'(s);
    endfunction

    assign open_win  = vblnk & ~vblnk_d;
    assign close_win = (vcount == 11'(CLOSE_LINE)) | ~vblnk;
    assign pending   = req & ~served;
    assign idle      = (state == IDLE);

    // First pending requester at or after ptr, wrapping around.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!hit && pending[wrap_add(ptr, k)]) begin
                hit     = 1'b1;
                hit_idx = wrap_add(ptr, k);
            end
        end
    end

    always_comb begin
        state_n  = state;
        gnt_n    = gnt;
        ptr_n    = ptr;
        owner_n  = owner;
        served_n = served;
        cnt_n    = cnt;
        fs_n     = 1'b0;
        to_n     = 1'b0;
        ov_n     = 1'b0;
        fc_n     = frame_cnt;
        unique case (state)
            IDLE: begin
                if (open_win) state_n = ARB;
            end
            ARB: begin
                if (close_win) begin
                    state_n = IDLE;
                end else if (hit) begin
                    gnt_n          = '0;
                    gnt_n[hit_idx] = 1'b1;
                    owner_n        = hit_idx;
                    cnt_n          = '0;
                    state_n        = GRANT;
                end
            end
            GRANT: begin
                cnt_n = cnt + 1'b1;
                // done beats close, close beats timeout
                if (done[owner]) begin
                    gnt_n           = '0;
                    served_n[owner] = 1'b1;
                    ptr_n           = wrap_add(owner, 1);
                    state_n         = ARB;
                end else if (close_win) begin
                    gnt_n           = '0;
                    ov_n            = 1'b1;
                    served_n[owner] = 1'b1;
                    state_n         = IDLE;
                end else if (cnt == CW'(MAX_CYCLES - 1)) begin
                    gnt_n           = '0;
                    to_n            = 1'b1;
                    served_n[owner] = 1'b1;
                    ptr_n           = wrap_add(owner, 1);
                    state_n         = ARB;
                end
            end
            default: begin
                gnt_n   = '0;
                state_n = IDLE;
            end
        endcase
        // A window edge always restarts the frame, even mid-grant.
        if (open_win) begin
            fs_n     = 1'b1;
            fc_n     = frame_cnt + 16'd1;
            served_n = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            gnt         <= '0;
            ptr         <= '0;
            owner       <= '0;
            served      <= '0;
            cnt         <= '0;
            vblnk_d     <= 1'b1;
            frame_start <= 1'b0;
            timeout     <= 1'b0;
            overrun     <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            state       <= state_n;
            gnt         <= gnt_n;
            ptr         <= ptr_n;
            owner       <= owner_n;
            served      <= served_n;
            cnt         <= cnt_n;
            vblnk_d     <= vblnk;
            frame_start <= fs_n;
            timeout     <= to_n;
            overrun     <= ov_n;
            frame_cnt   <= fc_n;
        end
    end

endmodule

// File: tb/tb_vblank_scheduler.sv
// Scoreboard bench for vblank_scheduler: a per-frame grant model feeds
// expected grant records; a negedge monitor checks what the DUT does.
module tb_vblank_scheduler;

    localparam int N    = 4;
    localparam int MAXC = 16;
    localparam int VBS  = 60;
    localparam int CL   = 127;

    logic          clk = 1'b0;
    logic          rst;
    logic          vblnk;
    logic [10:0]   vcount;
    logic [N-1:0]  req;
    logic [N-1:0]  done;
    logic [N-1:0]  gnt;
    logic          frame_start;
    logic          timeout;
    logic          overrun;
    logic [15:0]   frame_cnt;
    logic          idle;

    vblank_scheduler #(
        .N_REQ(N),
        .MAX_CYCLES(MAXC),
        .CLOSE_LINE(CL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .vblnk(vblnk),
        .vcount(vcount),
        .req(req),
        .done(done),
        .gnt(gnt),
        .frame_start(frame_start),
        .timeout(timeout),
        .overrun(overrun),
        .frame_cnt(frame_cnt),
        .idle(idle)
    );

    always #5 clk = ~clk;

    // kind: 0 = done, 1 = timeout, 2 = overrun
    typedef struct packed {
        int idx;
        int len;
        int kind;
    } grant_t;

    grant_t exp_q[$];
    int     frame_q[$];
    int     vecs = 0;
    int     errs = 0;

    int     arr[N];
    int     hold[N];
    int     gcount[N];
    bit     dropped[N];
    bit     drop_en;
    bit     mon_on = 1'b0;
    int     mptr;
    int     mframes;

    task automatic check(input string name, input int act, input int exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic drive_cycle(input int v);
        vcount = 11'(v);
        vblnk  = (v >= VBS);
        for (int i = 0; i < N; i++) begin
            if (gnt[i] === 1'b1) gcount[i]++;
            else gcount[i] = 0;
            if (v == 0) dropped[i] = 1'b0;
            if (gnt[i] === 1'b1 && drop_en && $urandom_range(0, 3) == 0)
                dropped[i] = 1'b1;
            req[i] = (arr[i] >= 0) && (v >= arr[i]) && !dropped[i];
            if (gnt[i] === 1'b1) done[i] = (gcount[i] == hold[i]);
            else done[i] = ($urandom_range(0, 7) == 0);
        end
        @(posedge clk);
        #1;
    endtask

    // Walks one window grant by grant, in line units.
    task automatic model_frame();
        bit     served[N];
        int     t, c, k, pick, kind, i;
        grant_t g;
        for (int s = 0; s < N; s++) served[s] = 1'b0;
        mframes = (mframes + 1) & 16'hFFFF;
        frame_q.push_back(mframes);
        t = VBS + 1;
        while (t < CL) begin
            pick = -1;
            for (int s = 0; s < N; s++) begin
                i = (mptr + s) % N;
                if (pick < 0 && arr[i] >= 0 && arr[i] <= t && !served[i])
                    pick = i;
            end
            if (pick < 0) begin
                t++;
                continue;
            end
            c = t + 1;
            k = 1;
            while (1) begin
                if (k == hold[pick]) begin kind = 0; break; end
                if (c == CL) begin kind = 2; break; end
                if (k == MAXC) begin kind = 1; break; end
                c++;
                k++;
            end
            g.idx  = pick;
            g.len  = k;
            g.kind = kind;
            exp_q.push_back(g);
            served[pick] = 1'b1;
            if (kind == 2) break;
            mptr = (pick + 1) % N;
            t    = c + 1;
        end
    endtask

    task automatic run_frame();
        model_frame();
        for (int v = 0; v <= CL; v++) drive_cycle(v);
    endtask

    task automatic set_req(input int i, input int a, input int h);
        arr[i]  = a;
        hold[i] = h;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) set_req(i, -1, 0);
    endtask

    // Monitor
    bit     in_g = 1'b0;
    int     cur, len, kind, fe;
    grant_t g;

    function automatic int onehot_idx(input logic [N-1:0] x);
        for (int i = 0; i < N; i++) if (x[i]) return i;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (!mon_on) begin
            in_g = 1'b0;
        end else begin
            if (frame_start) begin
                check("frame_expected", int'(frame_q.size() > 0), 1);
                if (frame_q.size() > 0) begin
                    fe = frame_q.pop_front();
                    check("frame_cnt", int'(frame_cnt), fe);
                    check("idle_at_open", int'(idle), 0);
                end
            end
            if (gnt != '0) begin
                check("gnt_onehot", int'($onehot(gnt)), 1);
                check("pulse_in_grant", int'(timeout | overrun), 0);
                if (!in_g) begin
                    in_g = 1'b1;
                    cur  = onehot_idx(gnt);
                    len  = 1;
                end else begin
                    check("gnt_switch", onehot_idx(gnt), cur);
                    len++;
                end
            end else if (in_g) begin
                in_g = 1'b0;
                check("end_pulses", int'(timeout & overrun), 0);
                kind = overrun ? 2 : (timeout ? 1 : 0);
                check("grant_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    g = exp_q.pop_front();
                    check("grant_idx", cur, g.idx);
                    check("grant_len", len, g.len);
                    check("grant_end", kind, g.kind);
                    if (kind == 2) check("idle_after_overrun", int'(idle), 1);
                    if (kind == 1) check("busy_after_timeout", int'(idle), 0);
                end
            end else begin
                check("stray_pulse", int'(timeout | overrun), 0);
            end
        end
    end

    initial begin
        int bad;
        int gv;
        rst     = 1'b1;
        vcount  = 11'd70;
        vblnk   = 1'b1;
        req     = '1;
        done    = '0;
        drop_en = 1'b0;
        mptr    = 0;
        mframes = 0;
        for (int i = 0; i < N; i++) begin
            gcount[i]  = 0;
            dropped[i] = 1'b0;
            set_req(i, 0, 0);
        end

        // Reset released in the middle of a blanking window
        for (int v = 70; v <= 72; v++) drive_cycle(v);
        check("rst_gnt", int'(gnt), 0);
        check("rst_frame_cnt", int'(frame_cnt), 0);
        check("rst_idle", int'(idle), 1);
        check("rst_pulses", int'({frame_start, timeout, overrun}), 0);
        rst = 1'b0;
        bad = 0;
        for (int v = 73; v <= CL; v++) begin
            drive_cycle(v);
            if (gnt != '0 || frame_start || frame_cnt != 0 || !idle) bad = 1;
        end
        check("no_open_after_reset", bad, 0);
        clear_reqs();
        for (int v = 0; v <= CL; v++) begin
            drive_cycle(v);
            if (v == VBS) begin
                check("first_frame_start", int'(frame_start), 1);
                check("first_frame_cnt", int'(frame_cnt), 1);
            end
            if (v == VBS + 1) check("frame_start_once", int'(frame_start), 0);
        end
        mframes = 1;
        mon_on  = 1'b1;

        // Directed frames through the scoreboard
        for (int i = 0; i < N; i++) set_req(i, 0, 3);
        run_frame();
        clear_reqs(); set_req(2, 0, 4);
        run_frame();
        clear_reqs(); set_req(0, 0, 2); set_req(3, 0, 2);
        run_frame();
        clear_reqs(); set_req(1, 0, 0); set_req(2, 0, 2);
        run_frame();
        clear_reqs(); set_req(0, 120, 0);
        run_frame();
        clear_reqs(); set_req(0, 120, 7);
        run_frame();

        // Random frames
        drop_en = 1'b1;
        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < N; i++) begin
                int r;
                r = int'($urandom_range(0, 99));
                if ($urandom_range(0, 3) == 0) arr[i] = -1;
                else arr[i] = int'($urandom_range(40, 125));
                if (r < 70) hold[i] = int'($urandom_range(1, 12));
                else if (r < 85) hold[i] = int'($urandom_range(13, 20));
                else hold[i] = 0;
            end
            run_frame();
        end
        clear_reqs();
        drop_en = 1'b0;
        for (int v = 0; v <= 5; v++) drive_cycle(v);
        check("grant_queue_drained", exp_q.size(), 0);
        check("frame_queue_drained", frame_q.size(), 0);

        // Reset pulse in the middle of a grant
        mon_on = 1'b0;
        set_req(0, 0, 0);
        gv = -1;
        for (int v = 6; v <= 80; v++) begin
            drive_cycle(v);
            if (gnt != '0) begin
                gv = v;
                break;
            end
        end
        check("mid_pre_gnt", int'(gnt), 1);
        check("mid_pre_latency", gv, VBS + 1);
        if (gv < 0) gv = 80;
        rst = 1'b1;
        drive_cycle(gv + 1);
        rst = 1'b0;
        check("mid_rst_gnt", int'(gnt), 0);
        check("mid_rst_frame_cnt", int'(frame_cnt), 0);
        check("mid_rst_idle", int'(idle), 1);
        bad = 0;
        for (int v = gv + 2; v <= CL; v++) begin
            drive_cycle(v);
            if (gnt != '0 || frame_start) bad = 1;
        end
        check("mid_no_regrant", bad, 0);
        for (int v = 0; v <= CL; v++) begin
            drive_cycle(v);
            if (v == VBS) begin
                check("mid_next_frame_start", int'(frame_start), 1);
                check("mid_next_frame_cnt", int'(frame_cnt), 1);
            end
            if (v == VBS + 1) check("mid_next_gnt", int'(gnt), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
